// File: rtl/int_divide_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// int_divide_scheduler_pkg
// Shared types and constants for the per-core iterative integer divider and
// its request scheduler.
//   scalar_t            : 32-bit integer operand / result
//   local_thread_idx_t  : thread index within one core
//   div_state_t         : divider sequencing states
//   div_request_t       : latched operands and operation flags
// ---------------------------------------------------------------------------
package int_divide_scheduler_pkg;

    localparam int THREADS_PER_CORE = 4;
    localparam int DIV_ITERATIONS   = 32;

    typedef logic [31:0] scalar_t;
    typedef logic [$clog2(THREADS_PER_CORE)-1:0] local_thread_idx_t;

    typedef enum logic [1:0] {
        DIV_IDLE    = 2'd0,
        DIV_SETUP   = 2'd1,
        DIV_ITERATE = 2'd2,
        DIV_FINISH  = 2'd3
    } div_state_t;

    typedef struct packed {
        scalar_t dividend;
        scalar_t divisor;
        logic    is_signed;
        logic    is_remainder;
    } div_request_t;

endpackage

// File: rtl/int_divide_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Rotating-priority arbiter. The search starts at the priority pointer; when
// update_en is set and something wins, the pointer moves to winner+1 so the
// winner becomes lowest priority next time.
//   clk, reset  : clock, synchronous active-low reset (pointer -> 0)
//   request     : request vector
//   update_en   : advance the pointer past this cycle's winner
//   grant       : one-hot grant (combinational)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] request,
    input  logic               update_en,
    output logic [NUM_REQ-1:0] grant
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] idx;
    logic             found;

    always_comb begin
        grant  = '0;
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!found && request[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (update_en && found) begin
            ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule

// File: rtl/int_divide_scheduler.sv
// ---------------------------------------------------------------------------
// int_divide_scheduler
// Shared radix-2 restoring 32-bit divider with a round-robin request
// scheduler. One operation in flight; the result comes back as a one-cycle
// pulse tagged with the owning thread. A writeback rollback of the owner
// aborts the operation silently.
//   clk, reset              : clock, synchronous active-low reset
//   req_valid/dividend/
//   divisor/signed/remainder: per-thread request, held until granted
//   req_grant               : one-hot accept pulse (combinational, IDLE only)
//   wb_rollback_en/
//   wb_rollback_thread_idx  : rollback from writeback
//   div_result_valid        : one-cycle result pulse
//   div_result              : quotient or remainder, holds between pulses
//   div_result_thread_idx   : owner of the result
//   div_busy                : an operation is in progress
// ---------------------------------------------------------------------------
module int_divide_scheduler
    import int_divide_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = THREADS_PER_CORE,
    parameter int ITERATIONS = DIV_ITERATIONS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0][31:0]      req_dividend,
    input  logic [NUM_REQ-1:0][31:0]      req_divisor,
    input  logic [NUM_REQ-1:0]            req_signed,
    input  logic [NUM_REQ-1:0]            req_remainder,
    output logic [NUM_REQ-1:0]            req_grant,
    input  logic                          wb_rollback_en,
    input  local_thread_idx_t             wb_rollback_thread_idx,
    output logic                          div_result_valid,
    output scalar_t                       div_result,
    output local_thread_idx_t             div_result_thread_idx,
    output logic                          div_busy
);

    localparam int CNT_W = $clog2(ITERATIONS);

    // |x| for signed ops; two's complement wraps so |INT_MIN| = 0x80000000.
    function automatic scalar_t magnitude(input scalar_t x, input logic is_signed);
        logic signed [31:0] sx;
        sx = x;
        return (is_signed && (sx < 0)) ? scalar_t'(-sx) : x;
    endfunction

    function automatic scalar_t apply_sign(input scalar_t x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    div_state_t         state;
    div_request_t       req_q;
    local_thread_idx_t  owner;
    local_thread_idx_t  winner_idx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] arb_grant;
    logic               arb_en;
    logic               pick;
    logic               rollback_hit;

    scalar_t            rem;
    scalar_t            quot;
    scalar_t            b_mag;
    logic [CNT_W-1:0]   cnt;
    logic               q_neg;
    logic               r_neg;
    logic               div_zero;

    logic [32:0]        rem_shift;
    logic [32:0]        trial;
    scalar_t            q_final;
    scalar_t            r_final;

    // A thread being rolled back this cycle may not start a new divide.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] &&
                          !(wb_rollback_en && (wb_rollback_thread_idx == local_thread_idx_t'(i)));
        end
    end

    assign arb_en = reset && (state == DIV_IDLE);

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .request   (eligible & {NUM_REQ{arb_en}}),
        .update_en (arb_en),
        .grant     (arb_grant)
    );

    always_comb begin
        winner_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) winner_idx = local_thread_idx_t'(i);
        end
    end

    assign pick         = |arb_grant;
    assign req_grant    = arb_grant;
    assign div_busy     = (state != DIV_IDLE);
    assign rollback_hit = wb_rollback_en && (wb_rollback_thread_idx == owner);

    // One restoring step: shift {rem, quot} left, subtract |b| if it fits.
    // The partial remainder is always < |b| so a 33-bit trial suffices and
    // trial[32] is the borrow.
    assign rem_shift = {rem, quot[31]};
    assign trial     = rem_shift - {1'b0, b_mag};

    // Divide-by-zero results are returned raw, without sign fix-up.
    assign q_final = apply_sign(quot, q_neg && !div_zero);
    assign r_final = apply_sign(rem,  r_neg && !div_zero);

    // Control: state sequencing and registered outputs
    always_ff @(posedge clk) begin
        if (!reset) begin
            state                 <= DIV_IDLE;
            div_result_valid      <= 1'b0;
            div_result            <= '0;
            div_result_thread_idx <= '0;
        end else begin
            div_result_valid <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (pick) state <= DIV_SETUP;
                end
                DIV_SETUP: begin
                    if (rollback_hit)             state <= DIV_IDLE;
                    else if (req_q.divisor == '0) state <= DIV_FINISH;
                    else                          state <= DIV_ITERATE;
                end
                DIV_ITERATE: begin
                    if (rollback_hit)                           state <= DIV_IDLE;
                    else if (cnt == CNT_W'(ITERATIONS - 1))     state <= DIV_FINISH;
                end
                DIV_FINISH: begin
                    state <= DIV_IDLE;
                    if (!rollback_hit) begin
                        div_result            <= req_q.is_remainder ? r_final : q_final;
                        div_result_valid      <= 1'b1;
                        div_result_thread_idx <= owner;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    // Datapath: operand capture, setup and iteration (no reset needed)
    always_ff @(posedge clk) begin
        case (state)
            DIV_IDLE: begin
                if (pick) begin
                    req_q.dividend     <= req_dividend[winner_idx];
                    req_q.divisor      <= req_divisor[winner_idx];
                    req_q.is_signed    <= req_signed[winner_idx];
                    req_q.is_remainder <= req_remainder[winner_idx];
                    owner              <= winner_idx;
                end
            end
            DIV_SETUP: begin
                q_neg    <= req_q.is_signed && (req_q.dividend[31] ^ req_q.divisor[31]);
                r_neg    <= req_q.is_signed && req_q.dividend[31];
                b_mag    <= magnitude(req_q.divisor, req_q.is_signed);
                div_zero <= (req_q.divisor == '0);
                cnt      <= '0;
                if (req_q.divisor == '0) begin
                    quot <= '1;
                    rem  <= req_q.dividend;
                end else begin
                    quot <= magnitude(req_q.dividend, req_q.is_signed);
                    rem  <= '0;
                end
            end
            DIV_ITERATE: begin
                rem  <= trial[32] ? rem_shift[31:0] : trial[31:0];
                quot <= {quot[30:0], ~trial[32]};
                cnt  <= cnt + 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_int_divide_scheduler.sv
module tb_int_divide_scheduler;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req_valid;
    logic [3:0][31:0] req_dividend;
    logic [3:0][31:0] req_divisor;
    logic [3:0]       req_signed;
    logic [3:0]       req_remainder;
    logic [3:0]       req_grant;
    logic             wb_rollback_en;
    logic [1:0]       wb_rollback_thread_idx;
    logic             div_result_valid;
    logic [31:0]      div_result;
    logic [1:0]       div_result_thread_idx;
    logic             div_busy;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    int_divide_scheduler dut (
        .clk                    (clk),
        .reset                  (reset),
        .req_valid              (req_valid),
        .req_dividend           (req_dividend),
        .req_divisor            (req_divisor),
        .req_signed             (req_signed),
        .req_remainder          (req_remainder),
        .req_grant              (req_grant),
        .wb_rollback_en         (wb_rollback_en),
        .wb_rollback_thread_idx (wb_rollback_thread_idx),
        .div_result_valid       (div_result_valid),
        .div_result             (div_result),
        .div_result_thread_idx  (div_result_thread_idx),
        .div_busy               (div_busy)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_req(input int t, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic r);
        req_dividend[t]  = a;
        req_divisor[t]   = b;
        req_signed[t]    = s;
        req_remainder[t] = r;
        req_valid[t]     = 1'b1;
    endtask

    // Samples at negedge; returns the granted index.
    task automatic wait_grant(output int idx, output bit ok);
        ok  = 1'b0;
        idx = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (req_grant != 4'b0) begin
                ok = 1'b1;
                for (int i = 0; i < 4; i++) if (req_grant[i]) idx = i;
                break;
            end
        end
    endtask

    // Called just after the grant edge; lat counts edges from the grant edge.
    task automatic wait_valid(output int lat, output bit ok);
        ok  = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (div_result_valid) begin
                ok  = 1'b1;
                lat = n;
                break;
            end
        end
    endtask

    task automatic do_op(input int t, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic r,
                         output logic [31:0] res, output int lat, output int idx, output bit ok);
        int g;
        bit okg, okv;
        set_req(t, a, b, s, r);
        wait_grant(g, okg);
        @(posedge clk); #1;
        req_valid[t] = 1'b0;
        wait_valid(lat, okv);
        res = div_result;
        idx = div_result_thread_idx;
        ok  = okg && okv && (g == t);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        total++; if (req_grant !== 4'b0) $display("FAIL reset_grant got=%b want=0000", req_grant); else passed++;
        total++; if (div_result_valid !== 1'b0) $display("FAIL reset_valid got=%b want=0", div_result_valid); else passed++;
        total++; if (div_result !== 32'h0) $display("FAIL reset_result got=%h want=0", div_result); else passed++;
        total++; if (div_result_thread_idx !== 2'd0) $display("FAIL reset_idx got=%0d want=0", div_result_thread_idx); else passed++;
        total++; if (div_busy !== 1'b0) $display("FAIL reset_busy got=%b want=0", div_busy); else passed++;
        req_valid = 4'b0;
        reset = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned();
        logic [31:0] res; int lat, idx; bit ok;
        do_op(0, 32'd100, 32'd7, 1'b0, 1'b0, res, lat, idx, ok);
        total++; if (!ok) $display("FAIL udiv_handshake got=0 want=1"); else passed++;
        total++; if (res !== 32'd14) $display("FAIL udiv_q got=%h want=0000000e", res); else passed++;
        total++; if (lat !== 34) $display("FAIL udiv_latency got=%0d want=34", lat); else passed++;
        total++; if (idx !== 0) $display("FAIL udiv_idx got=%0d want=0", idx); else passed++;
        @(posedge clk); #1;
        total++; if (div_result_valid !== 1'b0) $display("FAIL udiv_pulse got=%b want=0", div_result_valid); else passed++;
        total++; if (div_result !== 32'd14) $display("FAIL udiv_hold got=%h want=0000000e", div_result); else passed++;
        do_op(0, 32'd100, 32'd7, 1'b0, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'd2) $display("FAIL udiv_r got=%h ok=%0d want=00000002", res, ok); else passed++;
        do_op(0, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b0, res, lat, idx, ok);
        total++; if (!ok || res !== 32'h24924916) $display("FAIL udiv_big_q got=%h want=24924916", res); else passed++;
        do_op(0, 32'hFFFFFF9C, 32'd7, 1'b0, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'd2) $display("FAIL udiv_big_r got=%h want=00000002", res); else passed++;
    endtask

    task automatic test_signed();
        logic [31:0] res; int lat, idx; bit ok;
        do_op(1, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b0, res, lat, idx, ok);
        total++; if (!ok || res !== 32'hFFFFFFF2) $display("FAIL sdiv_q got=%h want=fffffff2", res); else passed++;
        total++; if (idx !== 1) $display("FAIL sdiv_idx got=%0d want=1", idx); else passed++;
        do_op(1, 32'hFFFFFF9C, 32'd7, 1'b1, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'hFFFFFFFE) $display("FAIL sdiv_r got=%h want=fffffffe", res); else passed++;
        do_op(1, 32'd100, 32'hFFFFFFF9, 1'b1, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'd2) $display("FAIL sdiv_negb_r got=%h want=00000002", res); else passed++;
        do_op(1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b0, res, lat, idx, ok);
        total++; if (!ok || res !== 32'h80000000) $display("FAIL sdiv_intmin_q got=%h want=80000000", res); else passed++;
        do_op(1, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'h0) $display("FAIL sdiv_intmin_r got=%h want=00000000", res); else passed++;
    endtask

    task automatic test_div_zero();
        logic [31:0] res; int lat, idx; bit ok;
        do_op(0, 32'd55, 32'd0, 1'b0, 1'b0, res, lat, idx, ok);
        total++; if (!ok || res !== 32'hFFFFFFFF) $display("FAIL dz_u_q got=%h want=ffffffff", res); else passed++;
        total++; if (lat !== 2) $display("FAIL dz_latency got=%0d want=2", lat); else passed++;
        do_op(0, 32'd55, 32'd0, 1'b0, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'd55) $display("FAIL dz_u_r got=%h want=00000037", res); else passed++;
        do_op(2, 32'd55, 32'd0, 1'b1, 1'b0, res, lat, idx, ok);
        total++; if (!ok || res !== 32'hFFFFFFFF) $display("FAIL dz_s_q got=%h want=ffffffff", res); else passed++;
        do_op(2, 32'd55, 32'd0, 1'b1, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'd55) $display("FAIL dz_s_r got=%h want=00000037", res); else passed++;
        do_op(2, 32'hFFFFFFC9, 32'd0, 1'b1, 1'b1, res, lat, idx, ok);
        total++; if (!ok || res !== 32'hFFFFFFC9) $display("FAIL dz_s_raw_r got=%h want=ffffffc9", res); else passed++;
    endtask

    task automatic test_arbitration();
        int exp_g[4]   = '{0, 2, 3, 0};
        logic [31:0] exp_r[4] = '{32'd10, 32'd20, 32'd30, 32'd40};
        int g, lat; bit okg, okv;
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(0, 32'd10, 32'd0, 1'b0, 1'b1);
        set_req(2, 32'd20, 32'd0, 1'b0, 1'b1);
        set_req(3, 32'd30, 32'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            wait_grant(g, okg);
            total++; if (!okg || g !== exp_g[k]) $display("FAIL arb_order_%0d got=%0d want=%0d", k, g, exp_g[k]); else passed++;
            total++; if (div_busy !== 1'b0) $display("FAIL arb_idle_%0d got busy=%b want=0", k, div_busy); else passed++;
            @(posedge clk); #1;
            if (okg) req_valid[g] = 1'b0;
            if (k == 0) set_req(0, 32'd40, 32'd0, 1'b0, 1'b1);
            wait_valid(lat, okv);
            total++; if (!okv || div_result !== exp_r[k] || div_result_thread_idx !== 2'(exp_g[k]))
                $display("FAIL arb_result_%0d got=%h/%0d want=%h/%0d", k, div_result, div_result_thread_idx, exp_r[k], exp_g[k]);
            else passed++;
        end
        req_valid = 4'b0;
    endtask

    task automatic test_rollback();
        int g, lat; bit okg, okv; bit seen = 1'b0;
        set_req(1, 32'd100, 32'd7, 1'b0, 1'b0);
        wait_grant(g, okg);
        total++; if (!okg || g !== 1) $display("FAIL rb_grant got=%0d want=1", g); else passed++;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        set_req(2, 32'd100, 32'd7, 1'b0, 1'b1);
        for (int n = 1; n <= 11; n++) begin
            @(posedge clk); #1;
            if (div_result_valid) seen = 1'b1;
        end
        wb_rollback_en = 1'b1;
        wb_rollback_thread_idx = 2'd1;
        @(posedge clk); #1;
        if (div_result_valid) seen = 1'b1;
        total++; if (div_busy !== 1'b0) $display("FAIL rb_busy got=%b want=0", div_busy); else passed++;
        total++; if (seen !== 1'b0) $display("FAIL rb_no_result got=%b want=0", seen); else passed++;
        wb_rollback_thread_idx = 2'd2;
        #1;
        total++; if (req_grant !== 4'b0000) $display("FAIL rb_ineligible got=%b want=0000", req_grant); else passed++;
        wb_rollback_en = 1'b0;
        #1;
        total++; if (req_grant !== 4'b0100) $display("FAIL rb_next_grant got=%b want=0100", req_grant); else passed++;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        wait_valid(lat, okv);
        total++; if (!okv || div_result !== 32'd2 || div_result_thread_idx !== 2'd2)
            $display("FAIL rb_pending_result got=%h/%0d want=00000002/2", div_result, div_result_thread_idx);
        else passed++;

        // Rollback of a thread that does not own the divider
        set_req(0, 32'd100, 32'd7, 1'b0, 1'b0);
        wait_grant(g, okg);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        okv = 1'b0;
        lat = 0;
        for (int n = 1; n <= 100; n++) begin
            wb_rollback_en = (n >= 5 && n <= 8);
            wb_rollback_thread_idx = 2'd3;
            @(posedge clk); #1;
            if (div_result_valid) begin okv = 1'b1; lat = n; break; end
        end
        wb_rollback_en = 1'b0;
        total++; if (!okv || lat !== 34 || div_result !== 32'd14)
            $display("FAIL rb_other_thread got=%h lat=%0d want=0000000e lat=34", div_result, lat);
        else passed++;
    endtask

    task automatic test_reset_mid_op();
        int g, lat; bit okg, okv;
        set_req(2, 32'd1000, 32'd3, 1'b0, 1'b0);
        wait_grant(g, okg);
        total++; if (!okg || g !== 2) $display("FAIL rst_mid_grant got=%0d want=2", g); else passed++;
        @(posedge clk); #1;
        req_valid[2] = 1'b0;
        set_req(3, 32'd7, 32'd7, 1'b0, 1'b0);
        set_req(0, 32'd9, 32'd2, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        total++; if (div_busy !== 1'b0 || div_result_valid !== 1'b0 || div_result !== 32'h0 ||
                     div_result_thread_idx !== 2'd0 || req_grant !== 4'b0)
            $display("FAIL rst_mid_outputs got busy=%b vld=%b res=%h idx=%0d gnt=%b want all 0",
                     div_busy, div_result_valid, div_result, div_result_thread_idx, req_grant);
        else passed++;
        reset = 1'b1;
        #1;
        total++; if (req_grant !== 4'b0001) $display("FAIL rst_mid_rr got=%b want=0001", req_grant); else passed++;
        @(posedge clk); #1;
        req_valid = 4'b0;
        wait_valid(lat, okv);
        total++; if (!okv || div_result !== 32'd4 || div_result_thread_idx !== 2'd0)
            $display("FAIL rst_mid_after got=%h/%0d want=00000004/0", div_result, div_result_thread_idx);
        else passed++;
    endtask

    initial begin
        reset = 1'b0;
        req_valid = '0;
        req_dividend = '0;
        req_divisor = '0;
        req_signed = '0;
        req_remainder = '0;
        wb_rollback_en = 1'b0;
        wb_rollback_thread_idx = '0;
        @(posedge clk); #1;
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_arbitration();
        test_rollback();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/int_divide_scheduler.md
Name: int_divide_scheduler

Overview:
Shared iterative 32-bit integer divider plus its scheduler for one core. Threads in the integer execute path post scalar divide/remainder requests. A round-robin arbiter grants one thread at a time, and a radix-2 restoring datapath is sequenced for 32 iterations. A single-cycle result pulse is returned, tagged with the thread index; a writeback rollback of the owning thread aborts the operation.

Parameters:
NUM_REQ, THREADS_PER_CORE, number of requesting threads (index width = local_thread_idx_t)
ITERATIONS, 32, quotient bits produced, one per cycle

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-low reset
req_valid  in  NUM_REQ  per-thread request; held until granted
req_dividend  in  NUM_REQ x 32  dividend (scalar_t) per thread
req_divisor  in  NUM_REQ x 32  divisor (scalar_t) per thread
req_signed  in  NUM_REQ  1 = signed operation, 0 = unsigned
req_remainder  in  NUM_REQ  1 = return remainder, 0 = return quotient
req_grant  out  NUM_REQ  one-hot, one-cycle pulse: request accepted
wb_rollback_en  in  1  rollback from writeback
wb_rollback_thread_idx  in  local_thread_idx_t  thread being rolled back
div_result_valid  out  1  one-cycle result pulse
div_result  out  32  quotient or remainder
div_result_thread_idx  out  local_thread_idx_t  owner of the result
div_busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, rr pointer=0.
  - All outputs 0: req_grant, div_result_valid, div_result, div_result_thread_idx, div_busy.
- State machine: IDLE -> SETUP -> ITERATE -> FINISH -> IDLE.
- IDLE:
  - Round-robin pick among req_valid bits, starting at the rr pointer.
  - A request is ineligible in a cycle where wb_rollback_en is set and wb_rollback_thread_idx equals its index.
  - On a pick: req_grant pulses for one cycle in that same cycle (combinational); operands, op flags and owner are latched; rr pointer = winner+1 mod NUM_REQ; next state SETUP.
  - No eligible request: stay in IDLE.
- SETUP (1 cycle):
  - For signed ops, form magnitudes |a| and |b| as unsigned 32-bit values (|0x80000000| = 0x80000000).
  - q_neg = sign(a) XOR sign(b); r_neg = sign(a).
  - Divisor == 0: skip to FINISH with quotient=0xFFFFFFFF and remainder=dividend (raw, no sign fix-up).
  - Otherwise: clear the 33-bit partial remainder, load the quotient register with |a|, iteration counter=0, go to ITERATE.
- ITERATE (exactly 32 cycles):
  - Shift {rem, quot} left by 1.
  - trial = rem − {1'b0, |b|}; if no borrow, rem=trial and quot[0]=1.
  - Counter increments; after count 31 go to FINISH.
- FINISH (1 cycle):
  - Apply negation to the quotient if q_neg and to the remainder if r_neg (signed ops only).
  - Select the output by req_remainder; register div_result; pulse div_result_valid; go to IDLE.
  - INT_MIN / −1 yields quotient 0x80000000 and remainder 0 with no special case.
- Latency:
  - div_result_valid is asserted 34 cycles after the grant cycle (grant at cycle 0, valid at cycle 34).
  - Divide-by-zero: valid 2 cycles after grant.
- Rollback: wb_rollback_en with thread == owner while in SETUP/ITERATE/FINISH:
  - Abort to IDLE next cycle; no result pulse.
  - A new grant is allowed from the following IDLE cycle.
  - A rollback of a different thread has no effect.
- Output timing: div_result_valid and div_result_thread_idx are registered. div_result holds its last value when not valid. There is no backpressure; the consumer must accept in the pulse cycle.
- Throughput: at most one operation in flight; a new grant occurs no earlier than the cycle after FINISH.
- A dropped request (req_valid deasserted before grant) is legal and is simply not granted.

Decomposition:
- Shared package (defines):
  - div_state_t enum {DIV_IDLE, DIV_SETUP, DIV_ITERATE, DIV_FINISH}.
  - DIV_ITERATIONS = 32.
  - div_request_t struct {dividend, divisor, is_signed, is_remainder}.
- Natural sub-module: rr_arbiter (NUM_REQ-wide, request vector + update enable -> one-hot grant, rotating priority). Reused elsewhere for other shared int resources.
- The divider datapath stays inline.

Test Plan:
- Unsigned: thread 0, 100 / 7, quotient -> result 14 on cycle 34 after grant; same operands with remainder -> 2.
- Signed: thread 1, −100 / 7 -> quotient 0xFFFFFFF2 (−14), remainder 0xFFFFFFFE (−2); 0x80000000 / 0xFFFFFFFF -> 0x80000000, remainder 0.
- Divide by zero: 55 / 0 (signed and unsigned) -> quotient 0xFFFFFFFF, remainder 55, valid 2 cycles after grant.
- Arbitration: threads 0, 2, 3 request simultaneously from reset -> grants in order 0, 2, 3, each after the previous FINISH; thread 0 re-requests -> served after 3.
- Rollback: rollback the owner at iteration 10 -> no div_result_valid, div_busy drops next cycle, pending thread 2 is granted in the following IDLE cycle. Rollback of a non-owner -> the result completes normally.
- Reset mid-operation: reset=0 during ITERATE -> next cycle all outputs 0 and state IDLE; after release, a pending request is granted to thread 0 first.
